key_event_device: RTL and testbench

Memory-mapped, interrupt-capable key input peripheral for the processor's I/O bus. It synchronises and debounces an NKEYS-wide key vector and queues each accepted change in a FIFO of FIFO_DEPTH entries. Software pops events through a data register and manages status and interrupt enable through a control register. It replaces the single-entry key device with configurable width, a deep event queue, debounce, a press-only filter and an occupancy count.

---
 rtl/key_event_pkg.sv | 21 ++
 rtl/key_event_fifo.sv | 63 ++++++
 rtl/key_event_device.sv | 158 +++++++++++++++
 tb/tb_key_event_device.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared constants and types for the key event peripheral: control register
// offset, control/status bit positions and the control flag bundle.
package key_event_pkg;

    localparam logic [31:0] CTRL_OFFSET = 32'h100;

    localparam int unsigned RE_BIT  = 0;
    localparam int unsigned OR_BIT  = 2;
    localparam int unsigned IE_BIT  = 8;
    localparam int unsigned PO_BIT  = 9;
    localparam int unsigned CNT_LSB = 16;
    localparam int unsigned CNT_W   = 8;

    // Software-visible control flags held by the device.
    typedef struct packed {
        logic ie;   // interrupt enable
        logic po;   // press-only filter
        logic ovr;  // sticky overflow
    } ctrl_t;

endpackage

// File: rtl/key_event_fifo.sv
// Event queue: power-of-two depth, combinational head, occupancy count.
// A pop on empty is ignored; a push on full succeeds only alongside a pop.
module key_event_fifo
    import key_event_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop, do_push;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign dout   = mem_q[rptr_q];
    assign count  = count_q;
    assign do_pop = pop && !empty;
    // A full queue can still accept a push when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy next-state; pointers wrap modulo DEPTH.
    always_comb begin
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset as occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/key_event_device.sv
// Memory-mapped key input peripheral: synchronises and debounces KEY,
// queues accepted changes, exposes a data (pop) and a control register.
module key_event_device
    import key_event_pkg::*;
#(
    parameter int unsigned     BITS       = 32,
    parameter logic [BITS-1:0] BASE       = 32'hF0000010,
    parameter int unsigned     NKEYS      = 4,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     DEBOUNCE   = 4
) (
    input  logic             CLK,
    input  logic             LOCK,
    input  logic [BITS-1:0]  ABUS,
    inout  wire  [BITS-1:0]  DBUS,
    input  logic             WE,
    input  logic             FLUSH,
    input  logic [NKEYS-1:0] KEY,
    output logic             INTR,
    output logic             IRQ,
    output logic [15:0]      DEBUG
);

    localparam int unsigned     CW        = $clog2(DEBOUNCE) + 1;
    localparam int unsigned     QW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BITS-1:0] CTRL_ADDR = BITS'(BASE + CTRL_OFFSET);

    logic [NKEYS-1:0] s1_q, s2_q, s2d_q;
    logic [NKEYS-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             push_ev;
    ctrl_t            ctrl_q, ctrl_d;

    logic             sel_data, sel_ctrl;
    logic             rd_data, rd_ctrl, wr_ctrl;
    logic             drive_en;
    logic [BITS-1:0]  rdata;

    logic [NKEYS-1:0] fifo_dout;
    logic             fifo_full, fifo_empty;
    logic [QW-1:0]    fifo_count;
    logic [CNT_W-1:0] count8;
    logic [3:0]       stable4;
    logic             re;
    logic             unused_dbus;

    assign sel_data = (ABUS == BASE) && !FLUSH;
    assign sel_ctrl = (ABUS == CTRL_ADDR) && !FLUSH;
    assign rd_data  = sel_data && !WE;
    assign rd_ctrl  = sel_ctrl && !WE;
    assign wr_ctrl  = sel_ctrl && WE;

    // Synchroniser chain and debounce state; reset loads the live keys so a
    // key held through reset is already the debounced value.
    always_ff @(posedge CLK or negedge LOCK) begin
        if (!LOCK) begin
            s1_q     <= KEY;
            s2_q     <= KEY;
            s2d_q    <= KEY;
            stable_q <= KEY;
            cnt_q    <= '0;
        end else begin
            s1_q     <= KEY;
            s2_q     <= s1_q;
            s2d_q    <= s2_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Debounce: count while a new value holds steady, accept after DEBOUNCE.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        if ((s2_q == stable_q) || (s2_q != s2d_q)) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
            stable_d = s2_q;
            cnt_d    = '0;
            accept   = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Press-only mode drops events that contain no newly pressed key.
    assign push_ev = accept && (!ctrl_q.po || (|(s2_q & ~stable_q)));

    key_event_fifo #(
        .WIDTH (NKEYS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (LOCK),
        .push  (push_ev),
        .pop   (rd_data),
        .din   (s2_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Control flags next-state; an overflow in the same cycle beats a clear.
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d.ie = DBUS[IE_BIT];
            ctrl_d.po = DBUS[PO_BIT];
            if (!DBUS[OR_BIT]) begin
                ctrl_d.ovr = 1'b0;
            end
        end
        if (push_ev && fifo_full && !rd_data) begin
            ctrl_d.ovr = 1'b1;
        end
    end

    // Control flag register.
    always_ff @(posedge CLK or negedge LOCK) begin
        if (!LOCK) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign count8  = CNT_W'(fifo_count);
    assign stable4 = 4'(stable_q);
    assign re      = !fifo_empty;

    // Read data mux: head entry (or current keys when empty) or status word.
    always_comb begin
        rdata = '0;
        if (rd_data) begin
            rdata = fifo_empty ? BITS'(stable_q) : BITS'(fifo_dout);
        end else begin
            rdata[CNT_LSB +: CNT_W] = count8;
            rdata[IE_BIT]           = ctrl_q.ie;
            rdata[PO_BIT]           = ctrl_q.po;
            rdata[OR_BIT]           = ctrl_q.ovr;
            rdata[RE_BIT]           = re;
        end
    end

    assign drive_en = LOCK && (rd_data || rd_ctrl);
    assign DBUS     = drive_en ? rdata : 'z;

    // Only a few write-data bits carry meaning; the rest are don't-care.
    assign unused_dbus = ^DBUS;

    assign INTR  = ctrl_q.ie;
    assign IRQ   = ctrl_q.ie && re;
    assign DEBUG = {count8, stable4, ctrl_q.ie, ctrl_q.po, ctrl_q.ovr, re};

endmodule

// File: tb/tb_key_event_device.sv
// Bench for key_event_device: directed scenarios plus randomized keys and bus
// traffic, checked against a windowed behavioural model of acceptance.
module tb_key_event_device;

    localparam int          D     = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hF0000010;
    localparam logic [31:0] CTRL  = 32'hF0000110;

    logic        clk = 1'b0;
    logic        lock;
    logic [31:0] abus;
    logic        we, flush;
    logic [3:0]  key;
    wire         intr, irq;
    wire  [15:0] debug;
    wire  [31:0] dbus;
    logic [31:0] drv;
    logic        drv_en;
    logic [31:0] rd;

    assign dbus = drv_en ? drv : 'z;

    always #5 clk = ~clk;

    key_event_device #(
        .BITS       (32),
        .BASE       (BASE),
        .NKEYS      (4),
        .FIFO_DEPTH (DEPTH),
        .DEBOUNCE   (D)
    ) dut (
        .CLK   (clk),
        .LOCK  (lock),
        .ABUS  (abus),
        .DBUS  (dbus),
        .WE    (we),
        .FLUSH (flush),
        .KEY   (key),
        .INTR  (intr),
        .IRQ   (irq),
        .DEBUG (debug)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int q[$];
    int hist[$];
    int m_stable;
    bit m_ie, m_po, m_or;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_ctrl();
        logic [31:0] w;
        w        = '0;
        w[23:16] = 8'(q.size());
        w[9]     = m_po;
        w[8]     = m_ie;
        w[2]     = m_or;
        w[0]     = (q.size() != 0);
        return w;
    endfunction

    function automatic logic [15:0] exp_debug();
        return {8'(q.size()), 4'(m_stable), m_ie, m_po, m_or, q.size() != 0};
    endfunction

    // A change is accepted when the last D+1 synchronised samples agree and
    // differ from the debounced value; samples reach the debouncer 2 edges late.
    task automatic model_edge(input logic [3:0] k, input int op, input logic [31:0] wd,
                              input logic fl);
        int n, v;
        bit acc, push_ev, rdv, wrc;
        rdv = (op == 1) && !fl;
        wrc = (op == 3) && !fl;
        hist.push_back(int'(k));
        n   = hist.size();
        v   = hist[n-3];
        acc = (v != m_stable);
        for (int j = 0; j <= D; j++) begin
            if (hist[n-3-j] != v) acc = 0;
        end
        push_ev = 0;
        if (acc) begin
            push_ev  = !m_po || ((v & ~m_stable & 15) != 0);
            m_stable = v;
        end
        if (rdv && q.size() > 0) void'(q.pop_front());
        if (wrc) begin
            m_ie = wd[8];
            m_po = wd[9];
            if (!wd[2]) m_or = 0;
        end
        if (push_ev) begin
            if (q.size() < DEPTH) q.push_back(v);
            else m_or = 1;
        end
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    // One bus cycle, entered and left at a negedge.
    // op: 0 idle, 1 data read, 2 control read, 3 control write.
    task automatic cycle(input logic [3:0] k, input int op, input logic [31:0] wd,
                         input logic fl, output logic [31:0] rv);
        key    = k;
        flush  = fl;
        we     = (op == 3);
        abus   = (op == 1) ? BASE : (op >= 2) ? CTRL : 32'h0;
        drv    = wd;
        drv_en = (op == 3);
        #1;
        rv = dbus;
        if (!fl && op == 1) chk("data_rd", dbus, (q.size() > 0) ? 32'(q[0]) : 32'(m_stable));
        if (!fl && op == 2) chk("ctrl_rd", dbus, exp_ctrl());
        @(posedge clk);
        model_edge(k, op, wd, fl);
        #1;
        chk("debug", 32'(debug), 32'(exp_debug()));
        chk("irq", 32'(irq), 32'(m_ie && q.size() > 0));
        chk("intr", 32'(intr), 32'(m_ie));
        @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) cycle(k, 0, 32'h0, 1'b0, rd);
    endtask

    task automatic do_reset(input logic [3:0] k);
        @(negedge clk);
        lock   = 1'b0;
        key    = k;
        abus   = '0;
        we     = 1'b0;
        flush  = 1'b0;
        drv_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_debug", 32'(debug), {16'h0, 8'h0, k, 4'h0});
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_intr", 32'(intr), 32'h0);
        q.delete();
        hist.delete();
        repeat (D + 3) hist.push_back(int'(k));
        m_stable = int'(k);
        m_ie = 0;
        m_po = 0;
        m_or = 0;
        lock = 1'b1;
    endtask

    initial begin
        lock   = 1'b0;
        key    = '0;
        abus   = '0;
        we     = 1'b0;
        flush  = 1'b0;
        drv    = '0;
        drv_en = 1'b0;

        // Keys held through reset produce no event.
        do_reset(4'b0101);
        idle(4'b0101, 20);
        chk("hold_count", 32'(debug[15:8]), 32'h0);
        cycle(4'b0101, 2, 32'h0, 1'b0, rd);
        chk("hold_ctrl", rd, 32'h0);

        // Acceptance latency and first read.
        do_reset(4'b0000);
        for (int i = 0; i <= 6; i++) begin
            cycle(4'b0011, 0, 32'h0, 1'b0, rd);
            chk("lat_re", 32'(debug[0]), 32'(i == 6));
        end
        cycle(4'b0011, 2, 32'h0, 1'b0, rd);
        chk("plan_ctrl", rd, 32'h00010001);
        cycle(4'b0011, 1, 32'h0, 1'b0, rd);
        chk("plan_data", rd, 32'h3);
        chk("plan_re_after", 32'(debug[0]), 32'h0);

        // Bounce: short pulse aborts, steady change gives one event.
        do_reset(4'b0000);
        idle(4'b0001, 2);
        idle(4'b0000, 10);
        chk("bounce_none", 32'(debug[15:8]), 32'h0);
        idle(4'b0001, 8);
        chk("bounce_one", 32'(debug[15:8]), 32'h1);

        // Fill to full, overflow, clear OR with IE set, drain in order.
        do_reset(4'b0000);
        for (int v = 1; v <= 5; v++) idle(4'(v), 8);
        chk("ovf_count", 32'(debug[15:8]), 32'h4);
        chk("ovf_or", 32'(debug[1]), 32'h1);
        cycle(4'd5, 3, 32'h100, 1'b0, rd);
        chk("clr_or", 32'(debug[1]), 32'h0);
        chk("clr_ie", 32'(debug[3]), 32'h1);
        chk("clr_irq", 32'(irq), 32'h1);
        for (int v = 1; v <= 4; v++) begin
            cycle(4'd5, 1, 32'h0, 1'b0, rd);
            chk("drain", rd, 32'(v));
        end

        // Push into a full queue on the same edge as a pop.
        for (int v = 6; v <= 9; v++) idle(4'(v), 8);
        idle(4'd10, 6);
        cycle(4'd10, 1, 32'h0, 1'b0, rd);
        chk("pp_head", rd, 32'h6);
        chk("pp_or", 32'(debug[1]), 32'h0);
        chk("pp_count", 32'(debug[15:8]), 32'h4);
        for (int v = 7; v <= 10; v++) begin
            cycle(4'd10, 1, 32'h0, 1'b0, rd);
            chk("pp_drain", rd, 32'(v));
        end

        // Press-only filter and flushed read.
        do_reset(4'b0000);
        cycle(4'b0000, 3, 32'h200, 1'b0, rd);
        idle(4'b0011, 8);
        cycle(4'b0011, 1, 32'h0, 1'b0, rd);
        chk("po_press", rd, 32'h3);
        idle(4'b0001, 8);
        chk("po_release_cnt", 32'(debug[15:8]), 32'h0);
        chk("po_stable", 32'(debug[7:4]), 32'h1);
        idle(4'b0101, 8);
        chk("po_event", 32'(debug[15:8]), 32'h1);
        cycle(4'b0101, 1, 32'h0, 1'b1, rd);
        chk("flush_nopop", 32'(debug[15:8]), 32'h1);
        cycle(4'b0101, 1, 32'h0, 1'b0, rd);
        chk("po_data", rd, 32'h5);

        // Randomized keys and bus traffic against the model.
        do_reset(4'($urandom_range(0, 15)));
        begin
            logic [3:0] k;
            int hold, r, op;
            k    = key;
            hold = 0;
            for (int i = 0; i < 3000; i++) begin
                if (hold == 0) begin
                    k    = 4'($urandom_range(0, 15));
                    hold = $urandom_range(1, 9);
                end
                hold--;
                r  = $urandom_range(0, 9);
                op = (r <= 5) ? 0 : (r <= 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 0 : 3;
                cycle(k, op, $urandom(), 1'($urandom_range(0, 7) == 0), rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
